// File: rtl/tx_axis_downsizer.sv
// Wide AXI-Stream to 8-bit MAC transmit serialiser.
// Holding register H feeds output register O one kept byte per clock; also reports underrun and frame length.
module tx_axis_downsizer #(
    parameter int IN_BYTES = 8,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [8*IN_BYTES-1:0] tx_axis_tdata,
    input  logic [IN_BYTES-1:0]   tx_axis_tkeep,
    input  logic                  tx_axis_tvalid,
    input  logic                  tx_axis_tlast,
    input  logic                  tx_axis_tuser,
    output logic                  tx_axis_tready,
    output logic [7:0]            tx_axis_mac_tdata,
    output logic                  tx_axis_mac_tvalid,
    output logic                  tx_axis_mac_tlast,
    output logic                  tx_axis_mac_tuser,
    input  logic                  tx_axis_mac_tready,
    output logic [CNT_W-1:0]      frame_len,
    output logic                  frame_done,
    output logic                  underrun,
    output logic                  null_last_err
);

    localparam logic [IN_BYTES-1:0] MASK_ONE = {{(IN_BYTES-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [8*IN_BYTES-1:0] h_data;
    logic [IN_BYTES-1:0]   h_mask;
    logic                  h_last;
    logic                  h_user;
    logic                  hv;
    logic                  in_frame;
    logic [CNT_W-1:0]      count;

    logic                  adv;
    logic                  single;
    logic                  accept;
    logic [IN_BYTES-1:0]   low_bit;
    logic [IN_BYTES-1:0]   m_after;
    logic [7:0]            sel_byte;
    logic [CNT_W-1:0]      count_inc;

    always_comb begin
        // Isolate the lowest remaining byte; the one-hot select avoids a variable index mux.
        low_bit  = h_mask & (~h_mask + MASK_ONE);
        m_after  = h_mask & ~low_bit;
        sel_byte = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            sel_byte = sel_byte | (h_data[8*i +: 8] & {8{low_bit[i]}});
        end
        single         = hv && (m_after == '0);
        adv            = !tx_axis_mac_tvalid || tx_axis_mac_tready;
        tx_axis_tready = reset_n && (!hv || (adv && single));
        accept         = tx_axis_tvalid && tx_axis_tready;
        count_inc      = (&count) ? count : count + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_data             <= '0;
            h_mask             <= '0;
            h_last             <= 1'b0;
            h_user             <= 1'b0;
            hv                 <= 1'b0;
            in_frame           <= 1'b0;
            count              <= '0;
            tx_axis_mac_tdata  <= '0;
            tx_axis_mac_tvalid <= 1'b0;
            tx_axis_mac_tlast  <= 1'b0;
            tx_axis_mac_tuser  <= 1'b0;
            frame_len          <= '0;
            frame_done         <= 1'b0;
            underrun           <= 1'b0;
            null_last_err      <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            underrun      <= 1'b0;
            null_last_err <= 1'b0;

            if (tx_axis_mac_tvalid && tx_axis_mac_tready) begin
                if (tx_axis_mac_tlast) begin
                    frame_len  <= count_inc;
                    frame_done <= 1'b1;
                    count      <= '0;
                end else begin
                    count <= count_inc;
                end
            end

            if (adv) begin
                if (hv) begin
                    tx_axis_mac_tvalid <= 1'b1;
                    tx_axis_mac_tdata  <= sel_byte;
                    tx_axis_mac_tlast  <= h_last && single;
                    tx_axis_mac_tuser  <= h_last && h_user && single;
                    in_frame           <= !(h_last && single);
                    h_mask             <= m_after;
                    hv                 <= !single;
                end else begin
                    tx_axis_mac_tvalid <= 1'b0;
                    tx_axis_mac_tlast  <= 1'b0;
                    tx_axis_mac_tuser  <= 1'b0;
                    underrun           <= in_frame;
                end
            end

            // A beat is only accepted when H is empty or drains this cycle, so this overrides the pop.
            if (accept) begin
                if (|tx_axis_tkeep) begin
                    h_data <= tx_axis_tdata;
                    h_mask <= tx_axis_tkeep;
                    h_last <= tx_axis_tlast;
                    h_user <= tx_axis_tuser;
                    hv     <= 1'b1;
                end else if (tx_axis_tlast) begin
                    h_data        <= '0;
                    h_mask        <= MASK_ONE;
                    h_last        <= 1'b1;
                    h_user        <= 1'b1;
                    hv            <= 1'b1;
                    null_last_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_axis_downsizer.sv
// Bench for tx_axis_downsizer: byte-queue reference model checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_tx_axis_downsizer;

    localparam int IB = 8;
    localparam int CW = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [8*IB-1:0] tdata;
    logic [IB-1:0] tkeep;
    logic          tvalid, tlast, tuser, tready;
    logic [7:0]    mac_tdata;
    logic          mac_tvalid, mac_tlast, mac_tuser, mac_tready;
    logic [CW-1:0] frame_len;
    logic          frame_done, underrun, null_last_err;

    tx_axis_downsizer #(.IN_BYTES(IB), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_axis_tdata(tdata), .tx_axis_tkeep(tkeep), .tx_axis_tvalid(tvalid),
        .tx_axis_tlast(tlast), .tx_axis_tuser(tuser), .tx_axis_tready(tready),
        .tx_axis_mac_tdata(mac_tdata), .tx_axis_mac_tvalid(mac_tvalid),
        .tx_axis_mac_tlast(mac_tlast), .tx_axis_mac_tuser(mac_tuser),
        .tx_axis_mac_tready(mac_tready),
        .frame_len(frame_len), .frame_done(frame_done),
        .underrun(underrun), .null_last_err(null_last_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic l; logic u; } byte_t;

    int tests = 0, fails = 0;
    int cyc = 0;

    // reference model: every accepted byte not yet transferred, oldest first
    byte_t q[$];
    bit    model_ok = 0, o_full = 0, in_frame = 0, acc_evt = 0;
    bit    exp_fd = 0, exp_under = 0, exp_nle = 0;
    int    cnt = 0, exp_len = 0;

    // observed traffic for the directed checks
    byte_t log_b[$];
    int    log_c[$];
    int    n_fd = 0, n_under = 0, n_nle = 0;
    int    rdy_mode = 0, tog = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        int  h_rem;
        bit  adv, acc;
        byte_t b;
        int  hi;
        cyc++;
        if (!reset_n) begin
            q.delete();
            model_ok = 1; o_full = 0; in_frame = 0; cnt = 0; exp_len = 0;
            exp_fd = 0; exp_under = 0; exp_nle = 0; acc_evt = 0;
        end else if (model_ok) begin
            h_rem = q.size() - int'(o_full);
            adv   = !o_full || mac_tready;
            acc   = tvalid && (h_rem == 0 || (adv && h_rem == 1));
            exp_fd = 0; exp_under = 0; exp_nle = 0;
            if (o_full && mac_tready) begin
                b = q.pop_front();
                cnt++;
                if (b.l) begin
                    exp_len = (cnt > CMAX) ? CMAX : cnt;
                    exp_fd  = 1;
                    cnt     = 0;
                end
            end
            if (adv) begin
                if (h_rem > 0) begin
                    o_full   = 1;
                    in_frame = !q[0].l;
                end else begin
                    o_full    = 0;
                    exp_under = in_frame;
                end
            end
            if (acc) begin
                if (tkeep != '0) begin
                    hi = 0;
                    for (int i = 0; i < IB; i++) if (tkeep[i]) hi = i;
                    for (int i = 0; i < IB; i++) begin
                        if (tkeep[i]) begin
                            b.d = tdata[8*i +: 8];
                            b.l = tlast && (i == hi);
                            b.u = tlast && tuser && (i == hi);
                            q.push_back(b);
                        end
                    end
                end else if (tlast) begin
                    b.d = 8'h00; b.l = 1; b.u = 1;
                    q.push_back(b);
                    exp_nle = 1;
                end
            end
            acc_evt = acc;
        end
    end

    always @(negedge clk) begin
        byte_t b;
        bit    adv;
        int    h_rem;
        #1;
        if (model_ok) begin
            h_rem = q.size() - int'(o_full);
            adv   = !o_full || mac_tready;
            chk("tready", tready, reset_n && (h_rem == 0 || (adv && h_rem == 1)));
            chk("mac_tvalid", mac_tvalid, o_full);
            if (o_full) begin
                chk("mac_tdata", mac_tdata, q[0].d);
                chk("mac_tlast", mac_tlast, q[0].l);
                chk("mac_tuser", mac_tuser, q[0].u);
            end
            chk("underrun", underrun, exp_under);
            chk("frame_done", frame_done, exp_fd);
            chk("frame_len", frame_len, exp_len);
            chk("null_last_err", null_last_err, exp_nle);
        end else if (!reset_n) begin
            chk("tready_in_reset", tready, 1'b0);
        end
        if (reset_n && mac_tvalid && mac_tready) begin
            b.d = mac_tdata; b.l = mac_tlast; b.u = mac_tuser;
            log_b.push_back(b);
            log_c.push_back(cyc);
        end
        if (reset_n) begin
            n_fd    += int'(frame_done);
            n_under += int'(underrun);
            n_nle   += int'(null_last_err);
        end
    end

    always @(negedge clk) begin
        case (rdy_mode)
            0:       mac_tready = 1'b1;
            1:       mac_tready = ($urandom_range(0, 3) != 0);
            default: mac_tready = (tog % 3 == 0);
        endcase
        tog++;
    end

    task automatic clear_log();
        log_b.delete(); log_c.delete();
        n_fd = 0; n_under = 0; n_nle = 0;
    endtask

    task automatic send_beat(input logic [8*IB-1:0] d, input logic [IB-1:0] k,
                             input logic l, input logic u);
        int n = 0;
        @(negedge clk);
        tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!acc_evt && n < 100);
        if (!acc_evt) begin
            chk("beat_accept_timeout", 0, 1);
            tvalid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while ((q.size() != 0 || o_full) && n < 500) begin
            @(negedge clk); n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
        #2;
    endtask

    function automatic logic [8*IB-1:0] ramp(input int base);
        logic [8*IB-1:0] r;
        for (int i = 0; i < IB; i++) r[8*i +: 8] = 8'(base + i);
        return r;
    endfunction

    initial begin
        reset_n = 1'b0; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = 1'b0;
        mac_tready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_mac_tdata", mac_tdata, 8'h00);
        chk("reset_mac_tvalid", mac_tvalid, 1'b0);
        chk("reset_frame_len", frame_len, '0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // three full beats, ready always high
        clear_log();
        for (int b = 0; b < 3; b++) send_beat(ramp(8*b), 8'hFF, b == 2, 1'b0);
        drain();
        chk("t1_count", log_b.size(), 24);
        if (log_b.size() == 24) begin
            for (int i = 0; i < 24; i++) chk("t1_byte", log_b[i].d, 8'(i));
            chk("t1_last23", log_b[23].l, 1'b1);
            chk("t1_last22", log_b[22].l, 1'b0);
            chk("t1_span", log_c[23] - log_c[0], 23);
        end
        chk("t1_frame_len", frame_len, 16'd24);
        chk("t1_frame_done", n_fd, 1);
        chk("t1_underrun", n_under, 0);

        // sparse keep with abort
        clear_log();
        send_beat(64'h8877665544332211, 8'b10100101, 1'b1, 1'b1);
        drain();
        chk("t2_count", log_b.size(), 4);
        if (log_b.size() == 4) begin
            chk("t2_b0", log_b[0].d, 8'h11);
            chk("t2_b1", log_b[1].d, 8'h33);
            chk("t2_b2", log_b[2].d, 8'h66);
            chk("t2_b3", {log_b[3].d, log_b[3].l, log_b[3].u}, {8'h88, 2'b11});
            chk("t2_b2_flags", {log_b[2].l, log_b[2].u}, 2'b00);
        end
        chk("t2_frame_len", frame_len, 16'd4);

        // back-pressure 1,0,0 pattern
        clear_log();
        rdy_mode = 2;
        send_beat(ramp(8'h40), 8'hFF, 1'b0, 1'b0);
        send_beat(ramp(8'h48), 8'hFF, 1'b1, 1'b0);
        drain();
        rdy_mode = 0;
        chk("t3_count", log_b.size(), 16);
        if (log_b.size() == 16)
            for (int i = 0; i < 16; i++) chk("t3_byte", log_b[i].d, 8'(8'h40 + i));
        chk("t3_frame_len", frame_len, 16'd16);
        repeat (2) @(negedge clk);

        // input bubble mid-frame
        clear_log();
        send_beat(ramp(8'h80), 8'hFF, 1'b0, 1'b0);
        idle(12);
        send_beat(ramp(8'h88), 8'hFF, 1'b1, 1'b0);
        drain();
        chk("t4_underrun", n_under, 5);
        chk("t4_count", log_b.size(), 16);
        chk("t4_frame_len", frame_len, 16'd16);

        // empty beats
        clear_log();
        send_beat(64'hDEADBEEFDEADBEEF, 8'h00, 1'b0, 1'b0);
        send_beat(64'hDEADBEEFDEADBEEF, 8'h00, 1'b1, 1'b0);
        drain();
        chk("t5_count", log_b.size(), 1);
        if (log_b.size() == 1) chk("t5_abort", {log_b[0].d, log_b[0].l, log_b[0].u}, {8'h00, 2'b11});
        chk("t5_null_last", n_nle, 1);
        chk("t5_frame_len", frame_len, 16'd1);

        // reset after three bytes of a frame
        clear_log();
        send_beat(ramp(8'hA0), 8'hFF, 1'b1, 1'b0);
        tvalid = 1'b0;
        for (int n = 0; n < 50 && log_b.size() < 3; n++) @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0; tvalid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk("t6_tvalid_after_reset", mac_tvalid, 1'b0);
        chk("t6_len_after_reset", frame_len, '0);
        clear_log();
        send_beat(ramp(8'hC0), 8'hFF, 1'b1, 1'b0);
        drain();
        chk("t6_count", log_b.size(), 8);
        if (log_b.size() == 8) chk("t6_first", log_b[0].d, 8'hC0);
        chk("t6_frame_len", frame_len, 16'd8);

        // randomized traffic, back-pressure and occasional resets
        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            logic [8*IB-1:0] d;
            logic [IB-1:0] k;
            d = {$urandom, $urandom};
            k = ($urandom_range(0, 7) == 0) ? '0 : IB'($urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
            if ($urandom_range(0, 59) == 0) begin
                @(negedge clk);
                reset_n = 1'b0; tvalid = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            send_beat(d, k, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
